local_bus_master_fifo: RTL
==========================

# local_bus_master_fifo

Parametrised next-generation local-bus master, sitting between the inner byte-stream interface and the shared tri-state local bus. Inbound inner data is queued with its channel tag in a FIFO of configurable depth and written to the bus one word per transaction. The block reads words from the bus slave whenever the slave reports data and the inner transmit side is free. Relative to the first-generation master, it adds width, channel and depth parameters, backpressure, occupancy and overflow reporting, and an optional round-robin mode that lets writes proceed while the slave has data pending.

## Interface
- DATA_W, 8, data bits per word
- CHL_W, 2, channel tag bits; bus word is {chl, data}, CHL_W+DATA_W wide
- FIFO_AW, 3, FIFO address bits; depth = 2**FIFO_AW
- ARB_RR, 0, 0 = write only while lbus_tx_ready=0; 1 = round-robin write/read when both eligible

Ports:
- Clk  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high
- tx_data  out  DATA_W  word read from bus, toward inner side
- tx_data_valid  out  1  one-cycle qualifier for tx_data/tx_chl
- tx_chl  out  CHL_W  channel tag of tx_data
- rx_data  in  DATA_W  inner word to be written to bus
- rx_data_valid  in  1  push strobe for rx_data/rx_chl
- rx_chl  in  CHL_W  channel tag of rx_data
- rx_ready  out  1  registered; 1 when FIFO not full
- tx_busy  in  1  inner transmit side cannot accept a word
- lbus_tx_ready  in  1  slave holds a valid word on lbus_dat
- lbus_en  out  1  one-cycle transaction strobe
- lbus_op  out  2  01 = write, 10 = read, 00 = idle
- lbus_dat  inout  CHL_W+DATA_W  driven only while lbus_op==01, else high-Z
- fifo_level  out  FIFO_AW+1  current FIFO occupancy
- ovf_err  out  1  sticky: a push was dropped
- err_clr  in  1  clears ovf_err

## Operation
- Reset values: lbus_en=0, lbus_op=00, write register={CHL_W'0, all-ones data}, tx_data=0, tx_chl=0, tx_data_valid=0, rx_ready=1, fifo_level=0, ovf_err=0, state=IDLE, last_grant=READ.
- Push: on rx_data_valid, {rx_chl, rx_data} is written at the tail when the FIFO is not full, or when full with a pop on the same edge. Otherwise the word is dropped and ovf_err is set. Set wins over a simultaneous err_clr.
- Level arithmetic: level += push − pop. Pointers wrap modulo depth. Full is level==2**FIFO_AW.
- States: IDLE, WR, RD.
- IDLE drives lbus_en=0, lbus_op=00 and tx_data_valid=0, then evaluates eligibility:
  - wr_ok = FIFO non-empty and (lbus_tx_ready=0 or ARB_RR=1).
  - rd_ok = lbus_tx_ready=1 and tx_busy=0.
  - Only wr_ok → WR. Only rd_ok → RD. Neither → stay in IDLE.
  - Both (ARB_RR=1 only): go to the opposite of last_grant.
- WR: lbus_en=1, lbus_op=01, write register=FIFO head; pop; last_grant=WRITE; → IDLE.
- RD: lbus_en=1, lbus_op=10; tx_data/tx_chl sample lbus_dat; tx_data_valid=1; last_grant=READ; → IDLE.
- WR is never entered with an empty FIFO. The state machine never waits inside WR or RD.
- Reset asserted mid-transaction: every register returns to its reset value on that edge and FIFO contents are discarded.

## Timing
- Each transaction takes 2 cycles: decision edge (IDLE→WR/RD), then execute edge. The strobe is high for exactly one cycle, following the execute edge.
- Maximum bus throughput: one transaction every 2 cycles. lbus_en never stays high for two consecutive cycles.
- Read data is sampled at the execute edge, with the strobe rising at that same edge. The slave must hold the word stable while lbus_tx_ready=1 and advance on lbus_en with op=10.
- Write data is valid on lbus_dat for the whole strobe cycle and is high-Z from the next edge.
- tx_busy and lbus_tx_ready are sampled only at the decision edge.
- fifo_level and rx_ready update on the edge after the push or pop.

## Test plan
- Reset, then push 3 words (ch1 0x11, ch2 0x22, ch3 0x33) with lbus_tx_ready=0.
  - Required: 3 write strobes, 2 cycles apart, lbus_dat = 0x111, 0x222, 0x333.
  - Required: fifo_level goes 3→0; lbus_dat is Z between strobes.
- Slave presents 0x2A5 with lbus_tx_ready=1 and tx_busy=0.
  - Required: tx_data=0xA5, tx_chl=2, tx_data_valid high for exactly 1 cycle, lbus_op=10.
- Hold tx_busy=1 with lbus_tx_ready=1.
  - Required: no read strobes.
  - Required: releasing tx_busy gives a read strobe 2 edges later.
- Push 9 words into a depth-8 FIFO with the bus blocked.
  - Required: rx_ready=0 after the 8th push and ovf_err=1 after the 9th; the first 8 words are written in order.
  - Required: err_clr clears ovf_err.
- ARB_RR=1, FIFO holding 2 words, lbus_tx_ready=1 constantly, tx_busy=0.
  - Required: strobe ops alternate W,R,W,R, starting with W.
- Assert Reset during the WR strobe cycle.
  - Required: next cycle lbus_en=0, lbus_op=00, fifo_level=0, lbus_dat Z.

Source files
------------

// File: rtl/local_bus_master_fifo_if.sv
// Inner byte-stream and local-bus control signals of the FIFO bus master.
// The tri-state data bus stays a plain inout on the master so that its net can be resolved at the board/top level.
interface local_bus_master_fifo_if #(
   parameter int DATA_W  = 8,
   parameter int CHL_W   = 2,
   parameter int FIFO_AW = 3
);
   logic [DATA_W-1:0]  tx_data;
   logic               tx_data_valid;
   logic [CHL_W-1:0]   tx_chl;
   logic [DATA_W-1:0]  rx_data;
   logic               rx_data_valid;
   logic [CHL_W-1:0]   rx_chl;
   logic               rx_ready;
   logic               tx_busy;
   logic               lbus_tx_ready;
   logic               lbus_en;
   logic [1:0]         lbus_op;
   logic [FIFO_AW:0]   fifo_level;
   logic               ovf_err;
   logic               err_clr;

   modport master (
      output tx_data, tx_data_valid, tx_chl, rx_ready, lbus_en, lbus_op, fifo_level, ovf_err,
      input  rx_data, rx_data_valid, rx_chl, tx_busy, lbus_tx_ready, err_clr
   );

   modport slave (
      input  tx_data, tx_data_valid, tx_chl, rx_ready, lbus_en, lbus_op, fifo_level, ovf_err,
      output rx_data, rx_data_valid, rx_chl, tx_busy, lbus_tx_ready, err_clr
   );
endinterface

// File: rtl/local_bus_master_fifo.sv
// Local-bus master: queues tagged inner words in a FIFO and writes them to the bus,
// reads slave words toward the inner side, optionally round-robin between the two.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | strobe low; evaluate write/read eligibility (decision edge)
// ST_WR   | next edge raises write strobe with FIFO head, pops FIFO
// ST_RD   | next edge raises read strobe and samples lbus_dat
module local_bus_master_fifo #(
   parameter int DATA_W  = 8,
   parameter int CHL_W   = 2,
   parameter int FIFO_AW = 3,
   parameter int ARB_RR  = 0
) (
   input  logic                      Clk,
   input  logic                      Reset,
   local_bus_master_fifo_if.master   lb,
   inout  wire [CHL_W+DATA_W-1:0]    lbus_dat
);
   localparam int                BUS_W    = CHL_W + DATA_W;
   localparam int                DEPTH    = 2**FIFO_AW;
   localparam logic [FIFO_AW:0]  LVL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]  LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
   localparam logic [1:0]        OP_IDLE  = 2'b00;
   localparam logic [1:0]        OP_WR    = 2'b01;
   localparam logic [1:0]        OP_RD    = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;
   typedef enum logic {GRANT_RD, GRANT_WR} grant_t;

   state_t              state, state_nxt;
   grant_t              last_grant, grant_nxt;
   logic [BUS_W-1:0]    mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
   logic [FIFO_AW:0]    level, level_nxt;
   logic [BUS_W-1:0]    wr_reg;
   logic                full, empty, push, pop, wr_ok, rd_ok;
   logic                en_nxt, txv_nxt;
   logic [1:0]          op_nxt;

   assign full  = (level == LVL_FULL);
   assign empty = (level == '0);
   // A full FIFO still accepts a word when the head leaves on the same edge.
   assign push  = lb.rx_data_valid && (!full || pop);
   assign wr_ok = !empty && (!lb.lbus_tx_ready || (ARB_RR != 0));
   assign rd_ok = lb.lbus_tx_ready && !lb.tx_busy;

   always_comb begin
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + LVL_ONE;
         2'b01:   level_nxt = level - LVL_ONE;
         default: level_nxt = level;
      endcase
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = last_grant;
      pop       = 1'b0;
      en_nxt    = 1'b0;
      op_nxt    = OP_IDLE;
      txv_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            // Both eligible only happens in round-robin mode.
            if (wr_ok && rd_ok)
               state_nxt = (last_grant == GRANT_WR) ? ST_RD : ST_WR;
            else if (wr_ok)
               state_nxt = ST_WR;
            else if (rd_ok)
               state_nxt = ST_RD;
         end
         ST_WR: begin
            en_nxt    = 1'b1;
            op_nxt    = OP_WR;
            pop       = 1'b1;
            grant_nxt = GRANT_WR;
            state_nxt = ST_IDLE;
         end
         ST_RD: begin
            en_nxt    = 1'b1;
            op_nxt    = OP_RD;
            txv_nxt   = 1'b1;
            grant_nxt = GRANT_RD;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= ST_IDLE;
         last_grant <= GRANT_RD;
      end else begin
         state      <= state_nxt;
         last_grant <= grant_nxt;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lb.lbus_en       <= 1'b0;
         lb.lbus_op       <= OP_IDLE;
         lb.tx_data       <= '0;
         lb.tx_chl        <= '0;
         lb.tx_data_valid <= 1'b0;
         wr_reg           <= {{CHL_W{1'b0}}, {DATA_W{1'b1}}};
      end else begin
         lb.lbus_en       <= en_nxt;
         lb.lbus_op       <= op_nxt;
         lb.tx_data_valid <= txv_nxt;
         if (pop)
            wr_reg <= mem[rd_ptr];
         if (txv_nxt) begin
            lb.tx_data <= lbus_dat[DATA_W-1:0];
            lb.tx_chl  <= lbus_dat[BUS_W-1:DATA_W];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         lb.rx_ready <= 1'b1;
         lb.ovf_err  <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         level       <= level_nxt;
         lb.rx_ready <= (level_nxt != LVL_FULL);
         if (lb.rx_data_valid && !push)
            lb.ovf_err <= 1'b1;
         else if (lb.err_clr)
            lb.ovf_err <= 1'b0;
      end
   end

   // Storage needs no reset; resetting the pointers discards the contents.
   always_ff @(posedge Clk) begin
      if (push)
         mem[wr_ptr] <= {lb.rx_chl, lb.rx_data};
   end

   assign lb.fifo_level = level;
   assign lbus_dat      = (lb.lbus_op == OP_WR) ? wr_reg : {BUS_W{1'bz}};
endmodule
